// File: rtl/stage_exe_md.sv
// Execute stage: forwarding muxes, ALU, and an iterative multiply/divide unit
// with HI/LO registers that stalls upstream while a mul/div is in flight.
module stage_exe_md #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CTRL_W  = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               flush,
  input  logic [DATA_W-1:0]  data_a,
  input  logic [DATA_W-1:0]  data_b,
  input  logic [DATA_W-1:0]  data_imm,
  input  logic [DATA_W-1:0]  npc,
  input  logic [1:0]         for_a,
  input  logic [1:0]         for_b,
  input  logic [DATA_W-1:0]  result_from_exe,
  input  logic [DATA_W-1:0]  result_from_mem,
  input  logic               use_imm,
  input  logic [3:0]         alu_op,
  input  logic [2:0]         md_op,
  input  logic               reg_dst,
  input  logic [RADDR_W-1:0] regaddr1,
  input  logic [RADDR_W-1:0] regaddr2,
  input  logic [CTRL_W-1:0]  ctrl_i,
  output logic               stall_o,
  output logic               valid_o,
  output logic [DATA_W-1:0]  out,
  output logic               zero,
  output logic [DATA_W-1:0]  jump_address,
  output logic [DATA_W-1:0]  data_b_o,
  output logic [RADDR_W-1:0] regaddr_o,
  output logic [CTRL_W-1:0]  ctrl_o
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_next;

  logic [DATA_W-1:0]   fwd_a, fwd_b, op_b, alu_res, out_next;
  logic [DATA_W-1:0]   hi, lo, opnd, dividend_raw, mag_a, mag_b;
  logic [2*DATA_W-1:0] acc, mul_next, div_next, prod_final;
  logic [DATA_W:0]     mul_sum, rem_shift, div_diff;
  logic [DATA_W-1:0]   hi_fin, lo_fin, quo, rem;
  logic [CNT_W-1:0]    count;
  logic                is_md, signed_op, a_neg, b_neg, start, last_iter;
  logic                is_div, neg_res, neg_rem, div_zero;

  always_comb begin
    fwd_a = data_a;
    fwd_b = data_b;
    if (for_a == 2'b01) fwd_a = result_from_exe;
    else if (for_a == 2'b10) fwd_a = result_from_mem;
    if (for_b == 2'b01) fwd_b = result_from_exe;
    else if (for_b == 2'b10) fwd_b = result_from_mem;
    op_b = use_imm ? data_imm : fwd_b;
  end

  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'b0000: alu_res = fwd_a & op_b;
      4'b0001: alu_res = fwd_a | op_b;
      4'b0010: alu_res = fwd_a + op_b;
      4'b0110: alu_res = fwd_a - op_b;
      4'b0111: alu_res = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      4'b1100: alu_res = ~(fwd_a | op_b);
      4'b1101: alu_res = fwd_a ^ op_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    out_next = alu_res;
    case (md_op)
      3'b001, 3'b010, 3'b011, 3'b100: out_next = '0;
      3'b101: out_next = hi;
      3'b110: out_next = lo;
      default: out_next = alu_res;
    endcase
  end

  assign is_md     = (md_op >= 3'b001) && (md_op <= 3'b100);
  assign start     = in_valid && is_md && !stall_o;
  assign last_iter = (count == CNT_W'(DATA_W - 1));
  assign signed_op = (md_op == 3'b001) || (md_op == 3'b011);
  assign a_neg     = signed_op && fwd_a[DATA_W-1];
  assign b_neg     = signed_op && op_b[DATA_W-1];
  assign mag_a     = a_neg ? -fwd_a : fwd_a;
  assign mag_b     = b_neg ? -op_b : op_b;

  // acc holds {partial product} for multiply, {remainder, quotient} for divide.
  always_comb begin
    mul_sum    = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next   = {mul_sum, acc[DATA_W-1:1]};
    rem_shift  = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    div_diff   = rem_shift - {1'b0, opnd};
    div_next   = div_diff[DATA_W] ? {rem_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                                  : {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    prod_final = neg_res ? -mul_next : mul_next;
    quo        = div_next[DATA_W-1:0];
    rem        = div_next[2*DATA_W-1:DATA_W];
    hi_fin     = prod_final[2*DATA_W-1:DATA_W];
    lo_fin     = prod_final[DATA_W-1:0];
    if (is_div) begin
      if (div_zero) begin
        hi_fin = dividend_raw;
        lo_fin = '1;
      end else begin
        hi_fin = neg_rem ? -rem : rem;
        lo_fin = neg_res ? -quo : quo;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = BUSY;
      BUSY: if (last_iter) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall_o = (state == BUSY);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count        <= '0;
      acc          <= '0;
      opnd         <= '0;
      dividend_raw <= '0;
      is_div       <= 1'b0;
      neg_res      <= 1'b0;
      neg_rem      <= 1'b0;
      div_zero     <= 1'b0;
      hi           <= '0;
      lo           <= '0;
    end else if (start) begin
      count        <= '0;
      acc          <= {{DATA_W{1'b0}}, mag_a};
      opnd         <= mag_b;
      dividend_raw <= fwd_a;
      is_div       <= (md_op == 3'b011) || (md_op == 3'b100);
      neg_res      <= a_neg ^ b_neg;
      neg_rem      <= a_neg;
      div_zero     <= (op_b == '0);
    end else if (stall_o) begin
      acc   <= is_div ? div_next : mul_next;
      count <= last_iter ? '0 : count + 1'b1;
      if (last_iter) begin
        hi <= hi_fin;
        lo <= lo_fin;
      end
    end
  end

  // Stalled or flushed cycles load a bubble so later stages see nothing.
  always_ff @(posedge clock) begin
    if (reset || stall_o || flush) begin
      valid_o      <= 1'b0;
      out          <= '0;
      zero         <= 1'b0;
      jump_address <= '0;
      data_b_o     <= '0;
      regaddr_o    <= '0;
      ctrl_o       <= '0;
    end else begin
      valid_o      <= in_valid;
      out          <= out_next;
      zero         <= (out_next == '0);
      jump_address <= npc + data_imm;
      data_b_o     <= fwd_b;
      regaddr_o    <= reg_dst ? regaddr1 : regaddr2;
      ctrl_o       <= ctrl_i;
    end
  end

endmodule

// File: doc/stage_exe_md.md
STAGE_EXE_MD -- requirements
Module: stage_exe_md

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width (even, >=8).
REQ-002 SHALL have parameter RADDR_W, default 5, destination register address width.
REQ-003 SHALL have parameter CTRL_W, default 6, width of opaque control bundle passed to later stages.
REQ-004 SHALL have ports: clock  in  1  clock; reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: in_valid  in  1  instruction present; flush  in  1  squash instruction entering output register.
REQ-006 SHALL have ports: data_a, data_b  in  DATA_W  register operands; data_imm  in  DATA_W  sign-extended immediate; npc  in  DATA_W  next PC.
REQ-007 SHALL have ports: for_a, for_b  in  2  forward select; result_from_exe, result_from_mem  in  DATA_W  forwarded values.
REQ-008 SHALL have ports: use_imm  in  1  B operand = data_imm; alu_op  in  4  ALU function; md_op  in  3  mul/div/HI-LO function.
REQ-009 SHALL have ports: reg_dst  in  1  select regaddr1 (1) or regaddr2 (0); regaddr1, regaddr2  in  RADDR_W; ctrl_i  in  CTRL_W.
REQ-010 SHALL have ports: stall_o  out  1  upstream must hold inputs; valid_o  out  1; out  out  DATA_W  result; zero  out  1.
REQ-011 SHALL have ports: jump_address  out  DATA_W; data_b_o  out  DATA_W  forwarded B for stores; regaddr_o  out  RADDR_W; ctrl_o  out  CTRL_W.

Function
REQ-012 SHALL select A/B operands: for_x=01 -> result_from_exe, 10 -> result_from_mem, 00/11 -> data_x; B then replaced by data_imm when use_imm=1.
REQ-013 SHALL implement alu_op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0), 1100 NOR, 1101 XOR, others -> 0; adds/subs wrap modulo 2^DATA_W.
REQ-014 SHALL implement md_op: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MFHI (out=HI), 110 MFLO (out=LO), 111 none.
REQ-015 SHALL hold DATA_W-bit HI and LO registers, reset to 0.
REQ-016 SHALL use FSM IDLE/BUSY; IDLE->BUSY when in_valid & md_op in {001..100} & !stall_o; BUSY->IDLE after exactly DATA_W cycles (iteration counter 0..DATA_W-1).
REQ-017 SHALL compute multiply by iterative shift-add, one bit per BUSY cycle; signed ops on operand magnitudes with final negation of 2*DATA_W product when signs differ; HI=upper, LO=lower half.
REQ-018 SHALL compute divide by restoring iteration, one quotient bit per cycle; LO=quotient, HI=remainder; signed: quotient negated if signs differ, remainder takes dividend sign.
REQ-019 SHALL, on divisor 0 (signed or unsigned), write LO=all ones, HI=dividend unmodified.
REQ-020 SHALL, for signed DIV of most-negative by -1, write LO=most-negative, HI=0.
REQ-021 SHALL write HI/LO on the clock edge ending the last BUSY cycle; first IDLE cycle sees new values.
REQ-022 SHALL drive stall_o=1 combinationally iff state=BUSY; inputs presented while stall_o=1 are not accepted.
REQ-023 SHALL update output register each accepted cycle: out, zero (out==0 of ALU result), jump_address=npc+data_imm (wrap), data_b_o=forwarded B (pre-imm mux), regaddr_o per reg_dst, ctrl_o=ctrl_i, valid_o=in_valid.
REQ-024 SHALL load a bubble (valid_o=0, ctrl_o=0, out=0) into output register while stall_o=1, and for the accepted MULT/MULTU/DIV/DIVU instruction ctrl_o passes unchanged with out=0.
REQ-025 SHALL, when flush=1, load a bubble regardless of inputs; flush does not abort a BUSY operation or HI/LO update.
REQ-026 SHALL give latency 1 cycle for ALU/MFHI/MFLO, DATA_W+1 cycles from MULT/DIV acceptance to next instruction acceptance.

Reset
REQ-027 SHALL on reset clear all outputs to 0, HI/LO to 0, FSM to IDLE, counter to 0; reset during BUSY aborts with no HI/LO write.

Verification
REQ-028 ADD, data_a=5, for_b=01, result_from_exe=0xFFFFFFFB -> next cycle out=0, zero=1, valid_o=1.
REQ-029 MULT -7 x 3 -> stall_o high 32 cycles, bubbles out; then MFHI=0xFFFFFFFF, MFLO=0xFFFFFFEB.
REQ-030 DIVU 100/7 -> LO=14, HI=2; DIV -100/7 -> LO=-14, HI=-2.
REQ-031 DIV 0x12345678/0 -> LO=0xFFFFFFFF, HI=0x12345678; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-032 reset asserted at BUSY cycle 10 of MULTU -> next cycle stall_o=0, HI=LO=0, all outputs 0.
REQ-033 flush=1 with valid SUB -> valid_o=0, ctrl_o=0; flush during BUSY -> HI/LO still written at cycle 32.
